// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: 4-way round-robin arbiter guarding one shared register.
// Optional macro SHARED_REG_LOCK_EN adds a lock port for multi-cycle holds.
module shared_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
`ifdef SHARED_REG_LOCK_EN
  input  logic [3:0]         lock,
`endif
  input  logic               clr,
  output logic [3:0]         gnt,
  output logic               ack,
  output logic [WIDTH-1:0]   q,
  output logic               busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_d;
  logic [1:0]       ptr, ptr_d;
  logic [1:0]       gidx, gidx_d;
  logic [3:0]       gnt_d;
  logic             ack_d;
  logic [WIDTH-1:0] q_d;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       cand;
  logic             wr;
  logic             stay;
`ifdef SHARED_REG_LOCK_EN
  logic [3:0]       hold, hold_d;
`endif

  assign busy = (state == GRANT);
  assign wr   = (state == GRANT) && req[gidx];

`ifdef SHARED_REG_LOCK_EN
  assign stay = wr && lock[gidx]
             && (({1'b0, hold} + 5'd1) < 5'(MAX_HOLD));
`else
  assign stay = 1'b0;
`endif

  // round-robin search starting just after the last winner
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // next-state, grant, ack and register-write decisions
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gidx_d  = gidx;
    gnt_d   = gnt;
    ack_d   = wr;
    q_d     = q;
`ifdef SHARED_REG_LOCK_EN
    hold_d  = hold;
`endif
    if (clr) begin
      q_d = '0;
    end else if (wr) begin
      q_d = wdata[int'(gidx)*WIDTH +: WIDTH];
    end
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          ptr_d   = win;
          gidx_d  = win;
          gnt_d   = 4'b0001 << win;
`ifdef SHARED_REG_LOCK_EN
          hold_d  = 4'd0;
`endif
        end else begin
          gnt_d = 4'b0000;
        end
      end
      GRANT: begin
        if (stay) begin
`ifdef SHARED_REG_LOCK_EN
          hold_d = hold + 4'd1;
`endif
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end
      end
    endcase
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= 2'd3;
      gidx  <= 2'd0;
      gnt   <= 4'b0000;
      ack   <= 1'b0;
      q     <= '0;
`ifdef SHARED_REG_LOCK_EN
      hold  <= 4'd0;
`endif
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      gidx  <= gidx_d;
      gnt   <= gnt_d;
      ack   <= ack_d;
      q     <= q_d;
`ifdef SHARED_REG_LOCK_EN
      hold  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: vector table, hand sequences and a data scoreboard.
// Lock-hold sequence runs only when SHARED_REG_LOCK_EN is defined.
module tb_shared_reg_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        clr;
  logic [3:0]  gnt;
  logic        ack;
  logic [7:0]  q;
  logic        busy;
`ifdef SHARED_REG_LOCK_EN
  logic [3:0]  lock;
`endif

  int errors = 0;
  int checks = 0;
  bit sb_on  = 0;
  logic [7:0] sb[$];

  shared_reg_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
`ifdef SHARED_REG_LOCK_EN
    .lock  (lock),
`endif
    .clr   (clr),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wd;
    logic        clr;
    logic [3:0]  gnt;
    logic        ack;
    logic [7:0]  q;
    logic        busy;
  } vec_t;

  vec_t tv[26];

  function automatic vec_t mk(logic [3:0] r, logic [31:0] w, logic c,
                              logic [3:0] g, logic a, logic [7:0] qq,
                              logic b);
    vec_t v;
    v.req = r; v.wd = w; v.clr = c;
    v.gnt = g; v.ack = a; v.q = qq; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every ack must carry the oldest outstanding data word
  always @(negedge clk) begin
    if (sb_on && ack) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("sb_q", {24'd0, q}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wA, wB, wC, wD, wE, wF;
    int r;
    logic [7:0] d;
    bit got, seen;

    wA = 32'h000000A5; wB = 32'h44332211; wC = 32'h00770000;
    wD = 32'h3C000000; wE = 32'h0000005A; wF = 32'h00990066;

    tv[0]  = mk(4'b0001, wA, 0, 4'b0001, 0, 8'h00, 1);
    tv[1]  = mk(4'b0001, wA, 0, 4'b0000, 1, 8'hA5, 0);
    tv[2]  = mk(4'b0000, wA, 0, 4'b0000, 0, 8'hA5, 0);
    tv[3]  = mk(4'b1111, wB, 0, 4'b0010, 0, 8'hA5, 1);
    tv[4]  = mk(4'b1111, wB, 0, 4'b0000, 1, 8'h22, 0);
    tv[5]  = mk(4'b1111, wB, 0, 4'b0100, 0, 8'h22, 1);
    tv[6]  = mk(4'b1111, wB, 0, 4'b0000, 1, 8'h33, 0);
    tv[7]  = mk(4'b1111, wB, 0, 4'b1000, 0, 8'h33, 1);
    tv[8]  = mk(4'b1111, wB, 0, 4'b0000, 1, 8'h44, 0);
    tv[9]  = mk(4'b1111, wB, 0, 4'b0001, 0, 8'h44, 1);
    tv[10] = mk(4'b1111, wB, 0, 4'b0000, 1, 8'h11, 0);
    tv[11] = mk(4'b1111, wB, 0, 4'b0010, 0, 8'h11, 1);
    tv[12] = mk(4'b0000, wB, 0, 4'b0000, 0, 8'h11, 0);
    tv[13] = mk(4'b0100, wC, 0, 4'b0100, 0, 8'h11, 1);
    tv[14] = mk(4'b0000, wC, 0, 4'b0000, 0, 8'h11, 0);
    tv[15] = mk(4'b0000, wC, 0, 4'b0000, 0, 8'h11, 0);
    tv[16] = mk(4'b1000, wD, 0, 4'b1000, 0, 8'h11, 1);
    tv[17] = mk(4'b1000, wD, 1, 4'b0000, 1, 8'h00, 0);
    tv[18] = mk(4'b0001, wE, 0, 4'b0001, 0, 8'h00, 1);
    tv[19] = mk(4'b0001, wE, 0, 4'b0000, 1, 8'h5A, 0);
    tv[20] = mk(4'b0000, wE, 1, 4'b0000, 0, 8'h00, 0);
    tv[21] = mk(4'b0001, wF, 0, 4'b0001, 0, 8'h00, 1);
    tv[22] = mk(4'b0101, wF, 0, 4'b0000, 1, 8'h66, 0);
    tv[23] = mk(4'b0101, wF, 0, 4'b0100, 0, 8'h66, 1);
    tv[24] = mk(4'b0100, wF, 0, 4'b0000, 1, 8'h99, 0);
    tv[25] = mk(4'b0000, wF, 0, 4'b0000, 0, 8'h99, 0);

    reset = 0; req = 0; wdata = 0; clr = 0;
`ifdef SHARED_REG_LOCK_EN
    lock = 0;
`endif
    #12;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      req = tv[i].req; wdata = tv[i].wd; clr = tv[i].clr;
      @(posedge clk); #1;
      chk($sformatf("v%0d_gnt", i), {28'd0, gnt}, {28'd0, tv[i].gnt});
      chk($sformatf("v%0d_ack", i), {31'd0, ack}, {31'd0, tv[i].ack});
      chk($sformatf("v%0d_q", i), {24'd0, q}, {24'd0, tv[i].q});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tv[i].busy});
    end
    clr = 0;

    // reset pulsed in the middle of a grant
    req = 4'b0100; wdata = 32'h00AB0000;
    @(posedge clk); #1;
    chk("mid_gnt", {28'd0, gnt}, 32'h4);
    #2 reset = 0;
    #1;
    chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk("mid_rst_q", {24'd0, q}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    req = 4'b1111; wdata = 32'h44332211;
    @(negedge clk); @(negedge clk); reset = 1;
    @(posedge clk); #1;
    chk("post_rst_gnt", {28'd0, gnt}, 32'h1);
    @(posedge clk); #1;
    chk("post_rst_q", {24'd0, q}, 32'h11);
    chk("post_rst_ack", {31'd0, ack}, 32'd1);
    req = 0;
    @(negedge clk); @(negedge clk);

    // randomized single-requester writes against the scoreboard
    sb_on = 1;
    for (int t = 0; t < 16; t++) begin
      r = $urandom_range(0, 3);
      d = 8'($urandom);
      wdata = $urandom;
      wdata[r*8 +: 8] = d;
      sb.push_back(d);
      req = 4'b0001 << r;
      got = 0; seen = 0;
      for (int c = 0; c < 6 && !got; c++) begin
        @(negedge clk);
        if (gnt == (4'b0001 << r)) seen = 1;
        if (ack) got = 1;
      end
      req = 0;
      chk($sformatf("sb%0d_ack", t), {31'd0, got}, 32'd1);
      chk($sformatf("sb%0d_gnt", t), {31'd0, seen}, 32'd1);
      @(negedge clk);
    end
    sb_on = 0;
    chk("sb_empty", sb.size(), 32'd0);

`ifdef SHARED_REG_LOCK_EN
    begin
      int gc, ac;
      reset = 0; #3; reset = 1;
      @(posedge clk); #1;
      req = 4'b0010; lock = 4'b0010; wdata = 32'h0000C300;
      gc = 0; ac = 0;
      for (int s = 1; s <= 6; s++) begin
        @(posedge clk); #1;
        if (gnt == 4'b0010) gc++;
        if (ack) ac++;
        if (s == 5) begin req = 0; lock = 0; end
      end
      chk("lock_gnt_cycles", gc, 32'd4);
      chk("lock_acks", ac, 32'd4);
      chk("lock_idle", {31'd0, busy}, 32'd0);
      chk("lock_q", {24'd0, q}, 32'hC3);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, width of the shared data register (1..32).
REQ-002 Parameter: MAX_HOLD, 4, maximum consecutive GRANT cycles for a locked requester (1..15).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  4  per-requester write request, level-sensitive.
REQ-006 Port: wdata  input  4*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: clr  input  1  synchronous clear of the shared register.
REQ-008 Port: gnt  output  4  registered one-hot grant; all zero when idle.
REQ-009 Port: ack  output  1  registered one-cycle pulse confirming a completed write.
REQ-010 Port: q  output  WIDTH  shared register contents.
REQ-011 Port: busy  output  1  high while the FSM is in GRANT.

Function
REQ-012 The FSM SHALL have two states, IDLE and GRANT.
REQ-013 IDLE: if any req bit is high, the FSM SHALL select a winner by round-robin, searching from index ptr+1 modulo 4 upward, load gnt one-hot with the winner, and go to GRANT; otherwise it SHALL stay in IDLE with gnt=0.
REQ-014 ptr (2 bits) SHALL update to the winner index on entry to GRANT; after reset it SHALL equal 3, so requester 0 has first priority.
REQ-015 GRANT: if req[g] is still high for granted index g, q SHALL load wdata slice g at the end of the cycle, and ack SHALL be high for exactly the following cycle.
REQ-016 GRANT with req[g] low (abort): q SHALL be unchanged, no ack SHALL be generated, and the FSM SHALL return to IDLE.
REQ-017 Without lock, GRANT SHALL last exactly one cycle and then return to IDLE, with gnt cleared; back-to-back grants therefore occur at most every 2 cycles.
REQ-018 Latency: req sampled high in IDLE at edge N -> gnt high in cycle N+1 -> q updated and ack high in cycle N+2.
REQ-019 clr high SHALL zero q at the next edge, with priority over any GRANT write in the same cycle; ack still pulses and FSM/ptr advance normally.
REQ-020 busy SHALL equal (state==GRANT); gnt SHALL never have more than one bit set.
REQ-021 Requests arriving while in GRANT SHALL be considered only in the next IDLE cycle; no request is queued or lost while req stays high.

Reset
REQ-022 reset low SHALL immediately force state=IDLE, gnt=0, ack=0, q=0, busy=0, ptr=3, hold counter=0, independent of clk.
REQ-023 Reset asserted mid-GRANT SHALL discard the in-flight write; after release the first grant SHALL follow REQ-013 from ptr=3.

Configuration
REQ-024 Macro SHARED_REG_LOCK_EN defined: add input port lock (4 bits); in GRANT, if req[g] and lock[g] are high and the hold count < MAX_HOLD, the FSM SHALL stay in GRANT, writing wdata slice g every cycle and pulsing ack each following cycle; reaching MAX_HOLD consecutive GRANT cycles or lock[g] low SHALL force return to IDLE.
REQ-025 Macro SHARED_REG_LOCK_EN undefined: no lock port and no hold counter; GRANT is always single-cycle per REQ-017.

Verification
REQ-026 Reset then req=4'b0001, wdata slice0=8'hA5 -> gnt=0001 next cycle, q=8'hA5 and ack=1 the cycle after.
REQ-027 req=4'b1111 held with distinct data -> grants in order 0,1,2,3,0 on every other cycle; q follows the matching slices.
REQ-028 req[2] raised, then dropped during its GRANT cycle -> no ack, q unchanged, FSM back to IDLE.
REQ-029 clr=1 in the same cycle as a GRANT write of 8'h3C -> q=0, ack=1.
REQ-030 reset pulsed low mid-GRANT -> all outputs 0 asynchronously, next grant goes to lowest active requester.
REQ-031 SHARED_REG_LOCK_EN defined, MAX_HOLD=4, req=lock=4'b0010 -> gnt=0010 for exactly 4 cycles, 4 ack pulses, then IDLE.
